// File: rtl/mem_fill_sequencer.sv
// Main-memory port sequencer behind the cache controller: line refills and
// single-word write-throughs, write-through first on a tie.
module mem_fill_sequencer #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                fill_req,
    input  logic [ADDR_W-1:0]                   fill_addr,
    input  logic                                wt_req,
    input  logic [ADDR_W-1:0]                   wt_addr,
    input  logic [DATA_W-1:0]                   wt_data,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [DATA_W-1:0]                   mem_wdata,
    input  logic [DATA_W-1:0]                   mem_rdata,
    input  logic                                mem_ack,
    output logic                                cache_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0]   cache_word,
    output logic [DATA_W-1:0]                   cache_wdata,
    output logic                                fill_done,
    output logic                                wt_done,
    output logic                                busy
);

    localparam int unsigned OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0]   LINE_MASK = ADDR_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        WT,
        FILL,
        FILL_LAST,
        DONE_WT,
        DONE_FILL
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [OFFSET_W-1:0]   cnt;
    logic [OFFSET_W-1:0]   cnt_next;
    logic [OFFSET_W-1:0]   cnt_inc;
    logic [ADDR_W-1:0]     addr_next;
    logic [DATA_W-1:0]     wdata_next;
    logic                  mem_req_next;
    logic                  mem_we_next;
    logic                  cache_we_next;
    logic [OFFSET_W-1:0]   cache_word_next;
    logic [DATA_W-1:0]     cache_wdata_next;
    logic                  fill_done_next;
    logic                  wt_done_next;
    logic                  busy_next;

    // Next state plus next value of every registered output
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        cnt_inc          = cnt + OFFSET_W'(1);
        addr_next        = mem_addr;
        wdata_next       = mem_wdata;
        cache_we_next    = 1'b0;
        cache_word_next  = cache_word;
        cache_wdata_next = cache_wdata;
        fill_done_next   = 1'b0;
        wt_done_next     = 1'b0;

        case (state)
            IDLE: begin
                if (wt_req) begin
                    state_next = WT;
                    addr_next  = wt_addr;
                    wdata_next = wt_data;
                end else if (fill_req) begin
                    state_next = FILL;
                    addr_next  = fill_addr & ~LINE_MASK;
                    cnt_next   = '0;
                end
            end
            WT: begin
                if (mem_ack) begin
                    state_next   = DONE_WT;
                    wt_done_next = 1'b1;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    cache_we_next    = 1'b1;
                    cache_word_next  = cnt;
                    cache_wdata_next = mem_rdata;
                    if (cnt == LAST_WORD) begin
                        state_next = FILL_LAST;
                    end else begin
                        cnt_next  = cnt_inc;
                        addr_next = (mem_addr & ~LINE_MASK) | ADDR_W'(cnt_inc);
                    end
                end
            end
            FILL_LAST: begin
                state_next     = DONE_FILL;
                fill_done_next = 1'b1;
            end
            DONE_WT:   state_next = IDLE;
            DONE_FILL: state_next = IDLE;
            default:   state_next = IDLE;
        endcase

        mem_req_next = (state_next == WT) || (state_next == FILL);
        mem_we_next  = (state_next == WT);
        busy_next    = (state_next != IDLE);
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cache_we    <= 1'b0;
            cache_word  <= '0;
            cache_wdata <= '0;
            fill_done   <= 1'b0;
            wt_done     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mem_req     <= mem_req_next;
            mem_we      <= mem_we_next;
            mem_addr    <= addr_next;
            mem_wdata   <= wdata_next;
            cache_we    <= cache_we_next;
            cache_word  <= cache_word_next;
            cache_wdata <= cache_wdata_next;
            fill_done   <= fill_done_next;
            wt_done     <= wt_done_next;
            busy        <= busy_next;
        end
    end

endmodule
